// File: rtl/vga_timing_pkg.sv
// Purpose : 640x480 VGA timing constants shared by generator and decoder, plus decoder FSM states.
// Latency : n/a (package only).
// Backpressure: n/a.
// Contents: H_/V_ timing localparams, LOCK_LINES, state_e enum, 10-bit saturating increment.
package vga_timing_pkg;

  localparam int H_ACTIVE     = 640;
  localparam int H_SYNC_START = 656;
  localparam int H_TOTAL      = 800;
  localparam int V_ACTIVE     = 480;
  localparam int V_SYNC_START = 490;
  localparam int V_TOTAL      = 525;
  localparam int LOCK_LINES   = 4;

  typedef enum logic [2:0] {
    SEARCH   = 3'd0,
    H_VERIFY = 3'd1,
    V_ARM    = 3'd2,
    V_VERIFY = 3'd3,
    LOCKED   = 3'd4
  } state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Purpose : registers one sync input and flags its rising edge.
// Latency : rise is combinational from d and the 1-cycle-old register.
// Backpressure: none.
// Ports   : clk, reset (sync, active-high), d (sync input), rise (d high while register low).
module sync_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic d_q;
  logic d_d;

  always_comb begin
    d_d = d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d_d;
    end
  end

  always_comb begin
    rise = d & ~d_q;
  end

endmodule

// File: rtl/vga_sync_decoder.sv
// Purpose : recovers pixel position and lock from an active-high hsync/vsync pair.
// Latency : every output registered; input at cycle t shows at t+1.
// Backpressure: none; free-running pixel-rate stream.
// Ports   : vga_clock, reset (sync, active-high), hsync, vsync in;
//           hcount, vcount, at_display_area, locked, h_period, v_period, error out.
module vga_sync_decoder
  import vga_timing_pkg::*;
#(
  parameter int P_H_ACTIVE     = H_ACTIVE,
  parameter int P_H_SYNC_START = H_SYNC_START,
  parameter int P_H_TOTAL      = H_TOTAL,
  parameter int P_V_ACTIVE     = V_ACTIVE,
  parameter int P_V_SYNC_START = V_SYNC_START,
  parameter int P_V_TOTAL      = V_TOTAL,
  parameter int P_LOCK_LINES   = LOCK_LINES
) (
  input  logic       vga_clock,
  input  logic       reset,
  input  logic       hsync,
  input  logic       vsync,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       at_display_area,
  output logic       locked,
  output logic [9:0] h_period,
  output logic [9:0] v_period,
  output logic       error
);

  localparam logic [9:0]  H_ACT   = 10'(P_H_ACTIVE);
  localparam logic [9:0]  H_LOAD  = 10'(P_H_SYNC_START);
  localparam logic [9:0]  H_LAST  = 10'(P_H_TOTAL - 1);
  localparam logic [9:0]  H_GOOD  = 10'(P_H_TOTAL);
  localparam logic [9:0]  V_ACT   = 10'(P_V_ACTIVE);
  localparam logic [9:0]  V_LOAD  = 10'(P_V_SYNC_START);
  localparam logic [9:0]  V_LAST  = 10'(P_V_TOTAL - 1);
  localparam logic [9:0]  V_GOOD  = 10'(P_V_TOTAL);
  localparam logic [7:0]  LOCK_N  = 8'(P_LOCK_LINES);
  localparam logic [11:0] TIMEOUT = 12'(2 * P_H_TOTAL);

  logic h_rise, v_rise;

  sync_edge_detect u_hsync_edge (.clk(vga_clock), .reset(reset), .d(hsync), .rise(h_rise));
  sync_edge_detect u_vsync_edge (.clk(vga_clock), .reset(reset), .d(vsync), .rise(v_rise));

  state_e      state_q, state_d;
  logic [9:0]  hcount_q, hcount_d, vcount_q, vcount_d;
  logic [9:0]  hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic [9:0]  h_period_q, h_period_d, v_period_q, v_period_d;
  logic [7:0]  good_q, good_d;
  logic [11:0] to_q, to_d;
  logic        error_q, error_d, disp_q, disp_d;

  logic [9:0]  h_meas, v_meas;
  logic        line_good, line_bad, frame_good, frame_bad, timeout, h_wrap;

  always_comb begin
    // Measurements as they would be latched at this cycle's edges.
    h_meas     = sat_inc10(hcnt_q);
    v_meas     = h_rise ? sat_inc10(vcnt_q) : vcnt_q;
    line_good  = h_rise && (h_meas == H_GOOD);
    line_bad   = h_rise && (h_meas != H_GOOD);
    frame_good = v_rise && (v_meas == V_GOOD);
    frame_bad  = v_rise && (v_meas != V_GOOD);
    timeout    = !h_rise && (to_q == TIMEOUT - 12'd1);

    // Position recovery: sync rises re-anchor the free-running counters.
    h_wrap   = !h_rise && (hcount_q == H_LAST);
    hcount_d = h_rise ? H_LOAD : (h_wrap ? 10'd0 : hcount_q + 10'd1);
    if (v_rise) begin
      vcount_d = V_LOAD;
    end else if (h_wrap) begin
      vcount_d = (vcount_q == V_LAST) ? 10'd0 : vcount_q + 10'd1;
    end else begin
      vcount_d = vcount_q;
    end

    hcnt_d     = h_rise ? 10'd0 : sat_inc10(hcnt_q);
    h_period_d = h_rise ? h_meas : h_period_q;
    vcnt_d     = v_rise ? 10'd0 : v_meas;
    v_period_d = v_rise ? v_meas : v_period_q;
    // Timer sticks at TIMEOUT so it fires once per outage.
    to_d       = h_rise ? 12'd0 : ((to_q == TIMEOUT) ? to_q : to_q + 12'd1);

    state_d = state_q;
    good_d  = good_q;
    error_d = 1'b0;
    case (state_q)
      SEARCH: begin
        if (h_rise) begin
          state_d = H_VERIFY;
          good_d  = 8'd0;
        end
      end
      H_VERIFY: begin
        if (line_bad) begin
          state_d = SEARCH;
        end else if (line_good) begin
          good_d = good_q + 8'd1;
          if (good_q + 8'd1 == LOCK_N) state_d = V_ARM;
        end
      end
      V_ARM: begin
        if (line_bad)    state_d = SEARCH;
        else if (v_rise) state_d = V_VERIFY;
      end
      V_VERIFY: begin
        if (line_bad || frame_bad) state_d = SEARCH;
        else if (frame_good)       state_d = LOCKED;
      end
      LOCKED: begin
        // Line and frame violations in one cycle merge into one pulse.
        if (line_bad || frame_bad) begin
          state_d = SEARCH;
          error_d = 1'b1;
        end
      end
      default: state_d = SEARCH;
    endcase
    if (timeout && (state_q != SEARCH)) begin
      state_d = SEARCH;
      error_d = (state_q == LOCKED);
    end

    // Built from next-state values so it lines up with the registered counters.
    disp_d = (state_d == LOCKED) && (hcount_d < H_ACT) && (vcount_d < V_ACT);
  end

  always_ff @(posedge vga_clock) begin
    if (reset) begin
      state_q    <= SEARCH;
      hcount_q   <= 10'd0;
      vcount_q   <= 10'd0;
      hcnt_q     <= 10'd0;
      vcnt_q     <= 10'd0;
      h_period_q <= 10'd0;
      v_period_q <= 10'd0;
      good_q     <= 8'd0;
      to_q       <= 12'd0;
      error_q    <= 1'b0;
      disp_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hcount_q   <= hcount_d;
      vcount_q   <= vcount_d;
      hcnt_q     <= hcnt_d;
      vcnt_q     <= vcnt_d;
      h_period_q <= h_period_d;
      v_period_q <= v_period_d;
      good_q     <= good_d;
      to_q       <= to_d;
      error_q    <= error_d;
      disp_q     <= disp_d;
    end
  end

  always_comb begin
    hcount          = hcount_q;
    vcount          = vcount_q;
    at_display_area = disp_q;
    locked          = (state_q == LOCKED);
    h_period        = h_period_q;
    v_period        = v_period_q;
    error           = error_q;
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Purpose : directed bench for vga_sync_decoder using a shrunken 16x10 timing.
// Latency : outputs sampled 1 time unit after each rising edge.
// Backpressure: none.
module tb_vga_sync_decoder;

  localparam int HA = 8, HSS = 10, HSW = 2, HT = 16;
  localparam int VA = 6, VSS = 7, VSW = 2, VT = 10, LL = 4;
  localparam int FRAME = HT * VT;

  logic       vga_clock = 1'b0;
  logic       reset = 1'b1;
  logic       hsync = 1'b0;
  logic       vsync = 1'b0;
  logic [9:0] hcount, vcount, h_period, v_period;
  logic       at_display_area, locked, error;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference generator state; ph/pv hold the generator position of the previous cycle.
  int gh = 0, gv = 0, ph = 0, pv = 0;
  int hadj = 0;
  bit vskip = 1'b0;
  bit hs_en = 1'b1;
  bit gen_run = 1'b0;

  always #20 vga_clock = ~vga_clock;

  vga_sync_decoder #(
    .P_H_ACTIVE(HA), .P_H_SYNC_START(HSS), .P_H_TOTAL(HT),
    .P_V_ACTIVE(VA), .P_V_SYNC_START(VSS), .P_V_TOTAL(VT),
    .P_LOCK_LINES(LL)
  ) dut (
    .vga_clock(vga_clock), .reset(reset), .hsync(hsync), .vsync(vsync),
    .hcount(hcount), .vcount(vcount), .at_display_area(at_display_area),
    .locked(locked), .h_period(h_period), .v_period(v_period), .error(error)
  );

  task automatic drive();
    hsync = hs_en && (gh >= HSS) && (gh < HSS + HSW);
    vsync = (gv >= VSS) && (gv < VSS + VSW);
  endtask

  // hadj=+1 makes the next line one clock short, -1 one clock long; vskip drops a line.
  task automatic advance();
    if (gh == HT - 1) begin
      gh = 0;
      if (gv == VT - 1) gv = 0;
      else if (vskip && gv == 2) begin gv = 4; vskip = 1'b0; end
      else gv = gv + 1;
    end else if (gh == 2 && hadj == 1) begin
      gh = 4; hadj = 0;
    end else if (gh == 2 && hadj == -1) begin
      hadj = 0;
    end else begin
      gh = gh + 1;
    end
  endtask

  task automatic step();
    @(posedge vga_clock);
    #1;
    ph = gh;
    pv = gv;
    if (gen_run) begin
      advance();
      drive();
    end
  endtask

  task automatic test_reset(input int cycles);
    reset = 1'b1; gen_run = 1'b0; hsync = 1'b0; vsync = 1'b0;
    repeat (cycles) step();
    n_cmp++; if (hcount !== 10'd0) begin n_bad++; $display("FAIL reset_hcount got %0d want 0", hcount); end
    n_cmp++; if (vcount !== 10'd0) begin n_bad++; $display("FAIL reset_vcount got %0d want 0", vcount); end
    n_cmp++; if (h_period !== 10'd0) begin n_bad++; $display("FAIL reset_h_period got %0d want 0", h_period); end
    n_cmp++; if (v_period !== 10'd0) begin n_bad++; $display("FAIL reset_v_period got %0d want 0", v_period); end
    n_cmp++;
    if ({at_display_area, locked, error} !== 3'b000) begin
      n_bad++; $display("FAIL reset_flags got disp/lock/err=%b want 000", {at_display_area, locked, error});
    end
    reset = 1'b0; gh = 0; gv = 0; hadj = 0; vskip = 1'b0; hs_en = 1'b1;
    drive();
    gen_run = 1'b1;
  endtask

  // From a generator started at (0,0): first rise at 10, good lines up to 74,
  // vsync rises at 112 (arm) and 272 (verify) -> locked visible after step 273.
  task automatic test_first_lock();
    int n = 0;
    while (locked !== 1'b1 && n < 2 * FRAME) begin step(); n++; end
    n_cmp++; if (n !== 273) begin n_bad++; $display("FAIL first_lock_cycle got %0d want 273", n); end
    n_cmp++; if (h_period !== 10'd16) begin n_bad++; $display("FAIL lock_h_period got %0d want 16", h_period); end
    n_cmp++; if (v_period !== 10'd10) begin n_bad++; $display("FAIL lock_v_period got %0d want 10", v_period); end
  endtask

  task automatic test_tracking();
    logic exp_disp;
    for (int i = 0; i < FRAME; i++) begin
      step();
      exp_disp = (ph < HA) && (pv < VA);
      n_cmp++;
      if (hcount !== 10'(ph) || vcount !== 10'(pv) || at_display_area !== exp_disp ||
          locked !== 1'b1 || error !== 1'b0 || h_period !== 10'd16 || v_period !== 10'd10) begin
        n_bad++;
        $display("FAIL track got h=%0d v=%0d disp=%b lock=%b err=%b hp=%0d vp=%0d want h=%0d v=%0d disp=%b lock=1 err=0 hp=16 vp=10",
                 hcount, vcount, at_display_area, locked, error, h_period, v_period, ph, pv, exp_disp);
      end
    end
  endtask

  task automatic relock();
    int n = 0;
    int errs = 0;
    while (locked !== 1'b1 && n < 3 * FRAME) begin
      step(); n++;
      if (error === 1'b1) errs++;
    end
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL relock got locked=%b want 1 after %0d cycles", locked, n); end
    n_cmp++; if (errs !== 0) begin n_bad++; $display("FAIL relock_error got %0d pulses want 0", errs); end
    step();
    n_cmp++;
    if (hcount !== 10'(ph) || vcount !== 10'(pv)) begin
      n_bad++; $display("FAIL relock_track got h=%0d v=%0d want h=%0d v=%0d", hcount, vcount, ph, pv);
    end
  endtask

  task automatic test_short_line();
    int n = 0;
    hadj = 1;
    while (error !== 1'b1 && n < 3 * HT) begin step(); n++; end
    n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL short_line_error got %b want 1", error); end
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL short_line_locked got %b want 0", locked); end
    n_cmp++; if (h_period !== 10'd15) begin n_bad++; $display("FAIL short_line_h_period got %0d want 15", h_period); end
    step();
    n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL short_line_pulse_width got %b want 0", error); end
    relock();
  endtask

  task automatic test_hsync_timeout();
    logic prev_hs;
    int n = 0;
    int early = 0;
    bit found = 1'b0;
    while (!found && n < 2 * FRAME) begin
      prev_hs = hsync;
      step(); n++;
      if (hsync && !prev_hs && gv == 1) found = 1'b1;
    end
    n_cmp++; if (!found) begin n_bad++; $display("FAIL timeout_setup got no rise want rise on line 1"); end
    hs_en = 1'b0;
    for (int k = 1; k <= 34; k++) begin
      step();
      if (k < 33 && error === 1'b1) early++;
      if (k == 32) begin
        n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL timeout_early got locked=%b want 1 at k=32", locked); end
      end
      if (k == 33) begin
        n_cmp++;
        if (locked !== 1'b0 || error !== 1'b1) begin
          n_bad++; $display("FAIL timeout_fire got locked=%b err=%b want 0/1 at k=33", locked, error);
        end
      end
      if (k == 34) begin
        n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL timeout_pulse got err=%b want 0", error); end
      end
    end
    n_cmp++; if (early !== 0) begin n_bad++; $display("FAIL timeout_spurious got %0d pulses want 0", early); end
    hs_en = 1'b1;
    relock();
  endtask

  task automatic test_short_frame();
    int n = 0;
    vskip = 1'b1;
    while (error !== 1'b1 && n < 2 * FRAME) begin step(); n++; end
    n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL short_frame_error got %b want 1", error); end
    n_cmp++; if (v_period !== 10'd9) begin n_bad++; $display("FAIL short_frame_v_period got %0d want 9", v_period); end
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL short_frame_locked got %b want 0", locked); end
    n_cmp++; if (h_period !== 10'd16) begin n_bad++; $display("FAIL short_frame_h_period got %0d want 16", h_period); end
    relock();
  endtask

  task automatic test_reset_locked();
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL pre_reset_locked got %b want 1", locked); end
    test_reset(1);
    test_first_lock();
  endtask

  // Good lines at 26/42/58, then a stall at cycle 66 stretches the next line to 17:
  // the decoder restarts, arms at 155, verifies at 273 and locks at 433 (step 434).
  task automatic test_hverify_bad_line();
    int errs = 0;
    test_reset(1);
    for (int n = 1; n <= 434; n++) begin
      step();
      if (n == 64) hadj = -1;
      if (error === 1'b1) errs++;
      if (n == 80) begin
        n_cmp++; if (h_period !== 10'd17) begin n_bad++; $display("FAIL hv_bad_h_period got %0d want 17", h_period); end
      end
      if (n == 300 || n == 433) begin
        n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL hv_bad_no_lock got locked=%b want 0 at %0d", locked, n); end
      end
      if (n == 434) begin
        n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL hv_bad_late_lock got locked=%b want 1 at 434", locked); end
      end
    end
    n_cmp++; if (errs !== 0) begin n_bad++; $display("FAIL hv_bad_error got %0d pulses want 0", errs); end
  endtask

  initial begin
    test_reset(2);
    test_first_lock();
    test_tracking();
    test_short_line();
    test_hsync_timeout();
    test_short_frame();
    test_reset_locked();
    test_hverify_bad_line();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
